// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: shared widths, FSM states and buffer entry layout for the fetch unit
package instruction_fetch_unit_pkg;
  localparam int OPCODE_WIDTH = 5;
  localparam int ADDR_WIDTH = 14;
  localparam int WORD_SIZE = OPCODE_WIDTH + ADDR_WIDTH;
  localparam int BUF_DEPTH = 2;
  localparam logic [ADDR_WIDTH-1:0] RESET_PC = '0;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} fetch_state_t;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [WORD_SIZE-1:0]  instr;
  } fetch_entry_t;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: instruction-memory read bus plus instruction-register valid/ready handshake
interface instruction_fetch_unit_if;
  import instruction_fetch_unit_pkg::*;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [WORD_SIZE-1:0]  mem_rdata;
  logic                  instr_valid;
  logic [WORD_SIZE-1:0]  instr_out;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_ready;
  modport master (
    output mem_req, mem_addr, instr_valid, instr_out, instr_pc,
    input  mem_gnt, mem_rvalid, mem_rdata, instr_ready
  );
  modport slave (
    input  mem_req, mem_addr, instr_valid, instr_out, instr_pc,
    output mem_gnt, mem_rvalid, mem_rdata, instr_ready
  );
endinterface

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// fetch_buffer: small synchronous FIFO of fetched {pc, instr} entries with flush
module fetch_buffer
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 din,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rd, wr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head = mem[rd];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr == LAST ? '0 : wr + PW'(1);
      if (do_pop) rd <= rd == LAST ? '0 : rd + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= din;
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC and request FSM issuing single-outstanding reads into a prefetch buffer
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  halt,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] fetch_pc,
  instruction_fetch_unit_if.master bus
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  fetch_state_t state, state_n;
  logic [ADDR_WIDTH-1:0] pc, req_pc;
  logic [CW-1:0] count;
  logic empty, full, push, pop, granted, room_wait;
  fetch_entry_t head, din;
  assign granted = state == REQ && bus.mem_gnt;
  assign pop = bus.instr_valid && bus.instr_ready;
  // a response arriving together with a redirect belongs to the old stream
  assign push = state == WAIT && bus.mem_rvalid && !redirect;
  assign room_wait = int'(count) + 1 - int'(pop) < BUF_DEPTH;
  assign din = {req_pc, bus.mem_rdata};
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  state_n = !redirect && !halt && !full ? REQ : IDLE;
      REQ:   state_n = bus.mem_gnt ? (redirect ? DRAIN : WAIT) : (redirect ? IDLE : REQ);
      WAIT:  state_n = bus.mem_rvalid ? (!redirect && !halt && room_wait ? REQ : IDLE)
                                      : (redirect ? DRAIN : WAIT);
      DRAIN: state_n = bus.mem_rvalid ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      pc <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      state <= state_n;
      if (redirect) pc <= redirect_pc;
      else if (granted) pc <= pc + ADDR_WIDTH'(1);
      if (granted) req_pc <= pc;
    end
  end
  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk(CLK),
    .rst(RST),
    .push(push),
    .pop(pop),
    .flush(redirect),
    .din(din),
    .head(head),
    .count(count),
    .empty(empty),
    .full(full)
  );
  assign bus.mem_req = state == REQ;
  assign bus.mem_addr = pc;
  assign bus.instr_valid = !empty;
  assign bus.instr_out = empty ? '0 : head.instr;
  assign bus.instr_pc = empty ? '0 : head.pc;
  assign fetch_pc = pc;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed scenarios against a bench-side instruction memory responder
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;
  logic clk = 1'b0;
  logic RST = 1'b1;
  logic halt = 1'b0;
  logic redirect = 1'b0;
  logic [ADDR_WIDTH-1:0] redirect_pc = '0;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  instruction_fetch_unit_if bus();
  instruction_fetch_unit dut (
    .CLK(clk),
    .RST(RST),
    .halt(halt),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .fetch_pc(fetch_pc),
    .bus(bus)
  );
  int total = 0;
  int bad = 0;
  bit auto_gnt = 1'b1, lat2 = 1'b0, manual = 1'b0, man_gnt = 1'b0, man_rvalid = 1'b0;
  logic [WORD_SIZE-1:0] man_rdata = '0;
  logic [ADDR_WIDTH-1:0] granted [$];
  logic [ADDR_WIDTH-1:0] pop_pc [$];
  logic [WORD_SIZE-1:0] pop_instr [$];
  bit acc1 = 1'b0, acc2 = 1'b0;
  logic [ADDR_WIDTH-1:0] a1 = '0, a2 = '0;

  always #5 clk = ~clk;

  function automatic logic [WORD_SIZE-1:0] mem_word(input logic [ADDR_WIDTH-1:0] a);
    return {a[4:0] ^ 5'h0B, a ^ 14'h1555};
  endfunction

  // observe accepted requests and completed pops exactly at the edge the DUT sees them
  always @(posedge clk) begin
    if (!RST && bus.mem_req && bus.mem_gnt) granted.push_back(bus.mem_addr);
    if (!RST && bus.instr_valid && bus.instr_ready) begin
      pop_pc.push_back(bus.instr_pc);
      pop_instr.push_back(bus.instr_out);
    end
    acc1 <= !RST && bus.mem_req && bus.mem_gnt;
    a1 <= bus.mem_addr;
    acc2 <= !RST && acc1;
    a2 <= a1;
  end

  always @(negedge clk) begin
    bus.mem_gnt = manual ? man_gnt : auto_gnt && bus.mem_req;
    bus.mem_rvalid = manual ? man_rvalid : (lat2 ? acc2 : acc1);
    bus.mem_rdata = manual ? man_rdata : mem_word(lat2 ? a2 : a1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    halt = 1'b0;
    redirect = 1'b0;
    bus.instr_ready = 1'b0;
    manual = 1'b0;
    auto_gnt = 1'b1;
    lat2 = 1'b0;
    repeat (3) step();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.instr_ready = 1'b0;
    repeat (3) step();
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%0h want=0", bus.mem_req); end
    total++; if (bus.mem_addr !== RESET_PC) begin bad++; $display("FAIL rst_mem_addr got=%0h want=0", bus.mem_addr); end
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL rst_instr_valid got=%0h want=0", bus.instr_valid); end
    total++; if (bus.instr_out !== '0) begin bad++; $display("FAIL rst_instr_out got=%0h want=0", bus.instr_out); end
    total++; if (bus.instr_pc !== '0) begin bad++; $display("FAIL rst_instr_pc got=%0h want=0", bus.instr_pc); end
    total++; if (fetch_pc !== RESET_PC) begin bad++; $display("FAIL rst_fetch_pc got=%0h want=0", fetch_pc); end
  endtask

  task automatic test_stream();
    int gb, pb, seen;
    do_reset();
    bus.instr_ready = 1'b1;
    gb = granted.size();
    pb = pop_pc.size();
    seen = 0;
    for (int i = 0; i < 2 && seen == 0; i++) begin
      step();
      seen = int'(bus.mem_req);
    end
    total++; if (seen != 1) begin bad++; $display("FAIL first_req got=%0d want=1", seen); end
    for (int i = 0; i < 40 && pop_pc.size() < pb + 4; i++) step();
    total++; if (pop_pc.size() < pb + 4) begin bad++; $display("FAIL stream_timeout got=%0d want=4", pop_pc.size() - pb); end
    for (int k = 0; k < 4; k++) begin
      total++; if (granted[gb+k] !== ADDR_WIDTH'(k)) begin bad++; $display("FAIL stream_addr%0d got=%0h want=%0h", k, granted[gb+k], k); end
      total++; if (pop_pc[pb+k] !== ADDR_WIDTH'(k)) begin bad++; $display("FAIL stream_pc%0d got=%0h want=%0h", k, pop_pc[pb+k], k); end
      total++; if (pop_instr[pb+k] !== mem_word(ADDR_WIDTH'(k))) begin bad++; $display("FAIL stream_instr%0d got=%0h want=%0h", k, pop_instr[pb+k], mem_word(ADDR_WIDTH'(k))); end
    end
  endtask

  task automatic test_full();
    int gb, seen;
    do_reset();
    gb = granted.size();
    repeat (12) step();
    total++; if (granted.size() - gb != 2) begin bad++; $display("FAIL full_grants got=%0d want=2", granted.size() - gb); end
    total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL full_valid got=%0h want=1", bus.instr_valid); end
    total++; if (bus.instr_pc !== 14'd0) begin bad++; $display("FAIL full_head_pc got=%0h want=0", bus.instr_pc); end
    total++; if (bus.instr_out !== mem_word(14'd0)) begin bad++; $display("FAIL full_head_instr got=%0h want=%0h", bus.instr_out, mem_word(14'd0)); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL full_req got=%0h want=0", bus.mem_req); end
    total++; if (fetch_pc !== 14'd2) begin bad++; $display("FAIL full_fetch_pc got=%0h want=2", fetch_pc); end
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    total++; if (bus.instr_pc !== 14'd1) begin bad++; $display("FAIL full_after_pop_pc got=%0h want=1", bus.instr_pc); end
    seen = 0;
    for (int i = 0; i < 4 && seen == 0; i++) begin
      step();
      seen = int'(bus.mem_req);
    end
    total++; if (seen != 1) begin bad++; $display("FAIL full_rereq got=%0d want=1", seen); end
    total++; if (bus.mem_addr !== 14'd2) begin bad++; $display("FAIL full_rereq_addr got=%0h want=2", bus.mem_addr); end
  endtask

  task automatic test_redirect();
    int gb, pb;
    do_reset();
    lat2 = 1'b1;
    gb = granted.size();
    for (int i = 0; i < 20 && granted.size() < gb + 2; i++) step();
    total++; if (granted.size() != gb + 2) begin bad++; $display("FAIL redir_setup got=%0d want=2", granted.size() - gb); end
    total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL redir_pre_valid got=%0h want=1", bus.instr_valid); end
    redirect = 1'b1;
    redirect_pc = 14'h1234;
    step();
    redirect = 1'b0;
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got=%0h want=0", bus.instr_valid); end
    total++; if (fetch_pc !== 14'h1234) begin bad++; $display("FAIL redir_fetch_pc got=%0h want=1234", fetch_pc); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL redir_drain_req got=%0h want=0", bus.mem_req); end
    step();
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL redir_discard got=%0h want=0", bus.instr_valid); end
    bus.instr_ready = 1'b1;
    pb = pop_pc.size();
    for (int i = 0; i < 20 && pop_pc.size() < pb + 1; i++) step();
    total++; if (granted[gb+2] !== 14'h1234) begin bad++; $display("FAIL redir_addr got=%0h want=1234", granted[gb+2]); end
    total++; if (pop_pc[pb] !== 14'h1234) begin bad++; $display("FAIL redir_pc got=%0h want=1234", pop_pc[pb]); end
    total++; if (pop_instr[pb] !== mem_word(14'h1234)) begin bad++; $display("FAIL redir_instr got=%0h want=%0h", pop_instr[pb], mem_word(14'h1234)); end
  endtask

  task automatic test_wrap();
    int gb, pb;
    do_reset();
    redirect = 1'b1;
    redirect_pc = 14'h3FFF;
    bus.instr_ready = 1'b1;
    gb = granted.size();
    pb = pop_pc.size();
    step();
    redirect = 1'b0;
    total++; if (fetch_pc !== 14'h3FFF) begin bad++; $display("FAIL wrap_redir_pc got=%0h want=3fff", fetch_pc); end
    for (int i = 0; i < 20 && granted.size() < gb + 1; i++) step();
    total++; if (granted[gb] !== 14'h3FFF) begin bad++; $display("FAIL wrap_addr got=%0h want=3fff", granted[gb]); end
    total++; if (fetch_pc !== 14'h0000) begin bad++; $display("FAIL wrap_fetch_pc got=%0h want=0", fetch_pc); end
    for (int i = 0; i < 20 && pop_pc.size() < pb + 2; i++) step();
    total++; if (pop_pc[pb] !== 14'h3FFF) begin bad++; $display("FAIL wrap_pc0 got=%0h want=3fff", pop_pc[pb]); end
    total++; if (pop_pc[pb+1] !== 14'h0000) begin bad++; $display("FAIL wrap_pc1 got=%0h want=0", pop_pc[pb+1]); end
    total++; if (pop_instr[pb+1] !== mem_word(14'h0000)) begin bad++; $display("FAIL wrap_instr1 got=%0h want=%0h", pop_instr[pb+1], mem_word(14'h0000)); end
  endtask

  task automatic test_halt();
    int gb, pb;
    do_reset();
    auto_gnt = 1'b0;
    bus.instr_ready = 1'b1;
    gb = granted.size();
    pb = pop_pc.size();
    step();
    halt = 1'b1;
    repeat (3) step();
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL halt_hold_req got=%0h want=1", bus.mem_req); end
    total++; if (bus.mem_addr !== 14'd0) begin bad++; $display("FAIL halt_hold_addr got=%0h want=0", bus.mem_addr); end
    auto_gnt = 1'b1;
    for (int i = 0; i < 10 && pop_pc.size() < pb + 1; i++) step();
    total++; if (pop_pc[pb] !== 14'd0) begin bad++; $display("FAIL halt_pc got=%0h want=0", pop_pc[pb]); end
    total++; if (pop_instr[pb] !== mem_word(14'd0)) begin bad++; $display("FAIL halt_instr got=%0h want=%0h", pop_instr[pb], mem_word(14'd0)); end
    repeat (5) step();
    total++; if (granted.size() != gb + 1) begin bad++; $display("FAIL halt_no_issue got=%0d want=1", granted.size() - gb); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL halt_idle_req got=%0h want=0", bus.mem_req); end
    halt = 1'b0;
    step();
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL halt_resume_req got=%0h want=1", bus.mem_req); end
    total++; if (bus.mem_addr !== 14'd1) begin bad++; $display("FAIL halt_resume_addr got=%0h want=1", bus.mem_addr); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    manual = 1'b1;
    man_gnt = 1'b0;
    man_rvalid = 1'b0;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 4 && bus.mem_req !== 1'b1; i++) step();
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL rstmid_setup got=%0h want=1", bus.mem_req); end
    man_gnt = 1'b1;
    step();
    man_gnt = 1'b0;
    total++; if (fetch_pc !== 14'd1) begin bad++; $display("FAIL rstmid_wait_pc got=%0h want=1", fetch_pc); end
    RST = 1'b1;
    step();
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rstmid_req got=%0h want=0", bus.mem_req); end
    total++; if (bus.mem_addr !== RESET_PC) begin bad++; $display("FAIL rstmid_addr got=%0h want=0", bus.mem_addr); end
    total++; if (fetch_pc !== RESET_PC) begin bad++; $display("FAIL rstmid_fetch_pc got=%0h want=0", fetch_pc); end
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%0h want=0", bus.instr_valid); end
    man_rvalid = 1'b1;
    man_rdata = 19'h5A5A5;
    RST = 1'b0;
    step();
    man_rvalid = 1'b0;
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL rstmid_late_rvalid got=%0h want=0", bus.instr_valid); end
    step();
    total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL rstmid_late_rvalid2 got=%0h want=0", bus.instr_valid); end
    total++; if (bus.instr_out !== '0) begin bad++; $display("FAIL rstmid_out got=%0h want=0", bus.instr_out); end
  endtask

  initial begin
    bus.instr_ready = 1'b0;
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_wrap();
    test_halt();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
